// File: rtl/arcade_input_cond_if.sv
// Pad/keyboard inputs and conditioned JOY outputs between hps_io and the core.
// master drives the raw inputs; slave is the conditioner.
interface arcade_input_cond_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [7:0]  joy1_out;
  logic [7:0]  joy2_out;
  logic        coin_busy;

  modport master (
    output ps2_key, joystick_0, joystick_1,
    input  joy1_out, joy2_out, coin_busy
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1,
    output joy1_out, joy2_out, coin_busy
  );
endinterface

// File: rtl/arcade_input_cond.sv
// Moon Patrol input conditioner: PS/2 key latches ORed with pads, coin requests shaped into
// COIN_PULSE-long pulses with a COIN_GAP lockout; 2-cycle input-to-output latency, no backpressure.
module arcade_input_cond #(
  parameter int COIN_PULSE = 3000000,
  parameter int COIN_GAP   = 3000000
) (
  input  logic               clk_sys,
  input  logic               reset,
  arcade_input_cond_if.slave io
);
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  localparam logic [21:0] PULSE_LOAD = 22'(COIN_PULSE - 1);
  localparam logic [21:0] GAP_LOAD   = 22'(COIN_GAP - 1);

  // Latch layout per player: R, L, D, U, fire, jump, start_a, start_b
  localparam int K_P1     = 0;
  localparam int K_P2     = 8;
  localparam int K_COIN_A = 16;
  localparam int K_COIN_B = 17;

  logic        last_toggle_q, last_toggle_d;
  logic        primed_q, primed_d;
  logic [17:0] key_q, key_d;
  logic [7:0]  pad1_q, pad1_d;
  logic [7:0]  pad2_q, pad2_d;
  logic        coin_req_prev_q, coin_req_prev_d;
  state_t      state_q, state_d;
  logic [21:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic [7:0]  joy1_out_q, joy1_out_d;
  logic [7:0]  joy2_out_q, joy2_out_d;
  logic        busy_q, busy_d;

  logic       ps2_evt;
  logic       pressed;
  logic       coin_req;
  logic       coin_evt;
  logic [6:0] p1_keys;
  logic [6:0] p2_keys;
  logic       unused_pad_hi;

  assign unused_pad_hi = ^{io.joystick_0[15:8], io.joystick_1[15:8]};

  assign ps2_evt  = primed_q && (io.ps2_key[10] != last_toggle_q);
  assign pressed  = io.ps2_key[9];
  assign coin_req = key_q[K_COIN_A] | key_q[K_COIN_B] | pad1_q[7] | pad2_q[7];
  assign coin_evt = coin_req & ~coin_req_prev_q;
  assign p1_keys  = {key_q[K_P1+6] | key_q[K_P1+7], key_q[K_P1+5:K_P1]};
  assign p2_keys  = {key_q[K_P2+6] | key_q[K_P2+7], key_q[K_P2+5:K_P2]};

  always_comb begin
    last_toggle_d   = io.ps2_key[10];
    primed_d        = 1'b1;
    pad1_d          = io.joystick_0[7:0];
    pad2_d          = io.joystick_1[7:0];
    coin_req_prev_d = coin_req;
    key_d           = key_q;
    if (ps2_evt) begin
      case ({io.ps2_key[8], io.ps2_key[7:0]})
        9'h175: key_d[K_P1+3]   = pressed;
        9'h172: key_d[K_P1+2]   = pressed;
        9'h16B: key_d[K_P1+1]   = pressed;
        9'h174: key_d[K_P1+0]   = pressed;
        9'h014: key_d[K_P1+4]   = pressed;
        9'h029: key_d[K_P1+5]   = pressed;
        9'h005: key_d[K_P1+6]   = pressed;
        9'h016: key_d[K_P1+7]   = pressed;
        9'h02D: key_d[K_P2+3]   = pressed;
        9'h02B: key_d[K_P2+2]   = pressed;
        9'h023: key_d[K_P2+1]   = pressed;
        9'h034: key_d[K_P2+0]   = pressed;
        9'h01C: key_d[K_P2+4]   = pressed;
        9'h01B: key_d[K_P2+5]   = pressed;
        9'h006: key_d[K_P2+6]   = pressed;
        9'h01E: key_d[K_P2+7]   = pressed;
        9'h02E: key_d[K_COIN_A] = pressed;
        9'h036: key_d[K_COIN_B] = pressed;
        default: ;
      endcase
    end
  end

  // Coin shaper: one request may be queued while a pulse or its lockout gap runs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (coin_evt) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      S_PULSE: begin
        if (coin_evt) pending_d = 1'b1;
        if (cnt_q == 22'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 22'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 22'd0) begin
          if (pending_q || coin_evt) begin
            state_d   = S_PULSE;
            cnt_d     = PULSE_LOAD;
            pending_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 22'd1;
          if (coin_evt) pending_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    joy1_out_d = {state_q == S_PULSE, pad1_q[6:0] | p1_keys};
    joy2_out_d = {1'b0, pad2_q[6:0] | p2_keys};
    busy_d     = (state_q != S_IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      last_toggle_q   <= 1'b0;
      primed_q        <= 1'b0;
      key_q           <= '0;
      pad1_q          <= '0;
      pad2_q          <= '0;
      coin_req_prev_q <= 1'b0;
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      pending_q       <= 1'b0;
      joy1_out_q      <= '0;
      joy2_out_q      <= '0;
      busy_q          <= 1'b0;
    end else begin
      last_toggle_q   <= last_toggle_d;
      primed_q        <= primed_d;
      key_q           <= key_d;
      pad1_q          <= pad1_d;
      pad2_q          <= pad2_d;
      coin_req_prev_q <= coin_req_prev_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      joy1_out_q      <= joy1_out_d;
      joy2_out_q      <= joy2_out_d;
      busy_q          <= busy_d;
    end
  end

  assign io.joy1_out  = joy1_out_q;
  assign io.joy2_out  = joy2_out_q;
  assign io.coin_busy = busy_q;
endmodule

// File: tb/tb_arcade_input_cond.sv
// Bench for arcade_input_cond with COIN_PULSE=4, COIN_GAP=3: directed stimulus pushes
// per-cycle expectations into a queue that a negedge monitor consumes.
module tb_arcade_input_cond;
  localparam int P = 4;
  localparam int G = 3;

  logic clk_sys = 1'b0;
  logic reset;
  logic tgl;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int         cyc;
    logic [7:0] j1;
    logic [7:0] j2;
    logic       busy;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  arcade_input_cond_if io();

  arcade_input_cond #(.COIN_PULSE(P), .COIN_GAP(G)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .io      (io.slave)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_mon = q.pop_front();
      n_cmp++;
      if (e_mon.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: cycle %0d passed unchecked (now %0d)", e_mon.name, e_mon.cyc, cyc);
      end else if ({io.joy1_out, io.joy2_out, io.coin_busy} !== {e_mon.j1, e_mon.j2, e_mon.busy}) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got joy1=%02h joy2=%02h busy=%0b, want joy1=%02h joy2=%02h busy=%0b",
                 e_mon.name, cyc, io.joy1_out, io.joy2_out, io.coin_busy,
                 e_mon.j1, e_mon.j2, e_mon.busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2(input logic ext, input logic [7:0] code, input logic pr);
    tgl = ~tgl;
    io.ps2_key = {tgl, pr, ext, code};
  endtask

  task automatic expect_at(input int c, input logic [7:0] j1, input logic [7:0] j2,
                           input logic b, input string nm);
    exp_t e;
    e.cyc = c; e.j1 = j1; e.j2 = j2; e.busy = b; e.name = nm;
    q.push_back(e);
  endtask

  // Coin bit high inside [p1s,p1e] or [p2s,p2e]; busy high inside [bs,be]; rest of outputs 0.
  task automatic expect_coin(input int c0, input int c1, input int p1s, input int p1e,
                             input int p2s, input int p2e, input int bs, input int be,
                             input string nm);
    logic [7:0] j;
    logic       b;
    for (int k = c0; k <= c1; k++) begin
      j = ((k >= p1s && k <= p1e) || (k >= p2s && k <= p2e)) ? 8'h80 : 8'h00;
      b = (k >= bs && k <= be);
      expect_at(k, j, 8'h00, b, nm);
    end
  endtask

  task automatic settle(input string nm);
    for (int i = 0; i < 100 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      $display("FAIL %s: %0d expectations never reached by cyc %0d", nm, q.size(), cyc);
      $fatal(1, "scoreboard timeout");
    end
  endtask

  initial begin
    int c;
    reset         = 1'b1;
    tgl           = 1'b1;
    io.ps2_key    = {1'b1, 1'b1, 1'b1, 8'h75};
    io.joystick_0 = '0;
    io.joystick_1 = '0;

    // Reset, then release with toggle already high: no spurious up-key latch
    for (int k = 1; k <= 3; k++) expect_at(k, 8'h00, 8'h00, 1'b0, "reset");
    tick(); tick(); tick();
    reset = 1'b0;
    for (int k = 4; k <= 8; k++) expect_at(k, 8'h00, 8'h00, 1'b0, "prime");
    settle("prime");

    // Extended up key press/release, exactly two-cycle latency
    c = cyc;
    ps2(1'b1, 8'h75, 1'b1);
    expect_at(c + 1, 8'h00, 8'h00, 1'b0, "up_lat1");
    expect_at(c + 2, 8'h08, 8'h00, 1'b0, "up_press");
    tick(); tick(); tick();
    c = cyc;
    ps2(1'b1, 8'h75, 1'b0);
    expect_at(c + 1, 8'h08, 8'h00, 1'b0, "up_hold");
    expect_at(c + 2, 8'h00, 8'h00, 1'b0, "up_release");
    settle("up");

    // Unlisted codes (non-extended 75, extended 14) are ignored
    c = cyc;
    expect_at(c + 2, 8'h00, 8'h00, 1'b0, "ign_0_75");
    expect_at(c + 3, 8'h00, 8'h00, 1'b0, "ign_1_14");
    ps2(1'b0, 8'h75, 1'b1);
    tick();
    ps2(1'b1, 8'h14, 1'b1);
    settle("ignore");

    // Both P1 start codes have separate latches, ORed
    c = cyc;
    expect_at(c + 2, 8'h40, 8'h00, 1'b0, "start_a");
    expect_at(c + 3, 8'h40, 8'h00, 1'b0, "start_ab");
    expect_at(c + 4, 8'h40, 8'h00, 1'b0, "start_b_only");
    expect_at(c + 5, 8'h00, 8'h00, 1'b0, "start_none");
    ps2(1'b0, 8'h05, 1'b1); tick();
    ps2(1'b0, 8'h16, 1'b1); tick();
    ps2(1'b0, 8'h05, 1'b0); tick();
    ps2(1'b0, 8'h16, 1'b0);
    settle("start");

    // P1 merge: pad right+fire with key left
    c = cyc;
    io.joystick_0 = 16'h0011;
    ps2(1'b1, 8'h6B, 1'b1);
    expect_at(c + 2, 8'h13, 8'h00, 1'b0, "p1_merge");
    tick(); tick(); tick();
    c = cyc;
    io.joystick_0 = 16'h0000;
    ps2(1'b1, 8'h6B, 1'b0);
    expect_at(c + 2, 8'h00, 8'h00, 1'b0, "p1_clear");
    settle("p1");

    // P2 pad fire+jump, then key up merged in
    c = cyc;
    io.joystick_1 = 16'h0030;
    expect_at(c + 1, 8'h00, 8'h00, 1'b0, "p2_lat1");
    expect_at(c + 2, 8'h00, 8'h30, 1'b0, "p2_pad");
    tick(); tick(); tick();
    c = cyc;
    ps2(1'b0, 8'h2D, 1'b1);
    expect_at(c + 2, 8'h00, 8'h38, 1'b0, "p2_merge");
    tick(); tick(); tick();
    c = cyc;
    io.joystick_1 = 16'h0000;
    ps2(1'b0, 8'h2D, 1'b0);
    expect_at(c + 2, 8'h00, 8'h00, 1'b0, "p2_clear");
    settle("p2");

    // Coin held 20 cycles: a single 4-cycle pulse, busy through the gap
    c = cyc;
    io.joystick_0 = 16'h0080;
    expect_coin(c + 1, c + 22, c + 3, c + 6, 1, 0, c + 3, c + 9, "coin_hold");
    repeat (20) tick();
    io.joystick_0 = 16'h0000;
    settle("coin_hold");

    // Three edges: second queued, third (during first pulse) dropped
    c = cyc;
    expect_coin(c + 1, c + 24, c + 3, c + 6, c + 10, c + 13, c + 3, c + 16, "coin_queue");
    io.joystick_0 = 16'h0080; tick();
    io.joystick_0 = 16'h0000; tick();
    io.joystick_0 = 16'h0080; tick();
    io.joystick_0 = 16'h0000; tick();
    io.joystick_0 = 16'h0080; tick();
    io.joystick_0 = 16'h0000;
    settle("coin_queue");

    // Coin key pressed mid-gap is served right after the gap
    c = cyc;
    expect_coin(c + 1, c + 22, c + 3, c + 6, c + 10, c + 13, c + 3, c + 16, "coin_key_gap");
    io.joystick_0 = 16'h0080; tick();
    io.joystick_0 = 16'h0000;
    repeat (4) tick();
    ps2(1'b0, 8'h2E, 1'b1);
    repeat (15) tick();
    ps2(1'b0, 8'h2E, 1'b0);
    settle("coin_key_gap");

    // Reset two cycles into a pulse clears outputs at once; next coin gives a full pulse
    c = cyc;
    expect_at(c + 1, 8'h00, 8'h00, 1'b0, "rst_pre1");
    expect_at(c + 2, 8'h00, 8'h00, 1'b0, "rst_pre2");
    expect_at(c + 3, 8'h80, 8'h00, 1'b1, "rst_pulse_on");
    expect_at(c + 4, 8'h00, 8'h00, 1'b0, "rst_mid_pulse");
    io.joystick_0 = 16'h0080; tick();
    io.joystick_0 = 16'h0000;
    tick(); tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    c = cyc;
    expect_coin(c + 1, c + 14, c + 5, c + 8, 1, 0, c + 5, c + 11, "rst_restart");
    tick(); tick();
    io.joystick_0 = 16'h0080; tick();
    io.joystick_0 = 16'h0000;
    settle("rst_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
